// File: rtl/tia_vga_pkg.sv
// Shared VGA timing constants, the RGB222 pixel type and the fixed TIA NTSC
// palette used by tia_vga_scaler and its line buffer.
package tia_vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    // Blend a hue channel weight with the 3-bit luminance, rounding toward the brighter value.
    function automatic logic [1:0] tint(input logic [1:0] base, input logic [2:0] lum);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, lum[2:1]} + {2'b00, lum[0]};
        return sum[2:1];
    endfunction

    function automatic rgb222_t tia_palette(input logic [6:0] idx);
        logic [5:0] base;
        rgb222_t    res;
        case (idx[6:3])
            4'd1:    base = 6'b11_10_00;
            4'd2:    base = 6'b11_01_00;
            4'd3:    base = 6'b11_00_00;
            4'd4:    base = 6'b11_00_01;
            4'd5:    base = 6'b10_00_10;
            4'd6:    base = 6'b01_00_11;
            4'd7:    base = 6'b00_00_11;
            4'd8:    base = 6'b00_01_11;
            4'd9:    base = 6'b00_10_11;
            4'd10:   base = 6'b00_11_11;
            4'd11:   base = 6'b00_11_10;
            4'd12:   base = 6'b00_11_00;
            4'd13:   base = 6'b01_11_00;
            4'd14:   base = 6'b10_11_00;
            4'd15:   base = 6'b11_10_01;
            default: base = 6'b00_00_00;
        endcase
        if (idx[6:3] == 4'd0) begin
            res.r = idx[2:1];
            res.g = idx[2:1];
            res.b = idx[2:1];
        end else begin
            res.r = tint(base[5:4], idx[2:0]);
            res.g = tint(base[3:2], idx[2:0]);
            res.b = tint(base[1:0], idx[2:0]);
        end
        return res;
    endfunction

    function automatic rgb222_t rgb_dim(input rgb222_t c);
        rgb222_t res;
        res.r = c.r >> 2'd1;
        res.g = c.g >> 2'd1;
        res.b = c.b >> 2'd1;
        return res;
    endfunction
endpackage

// File: rtl/tia_line_buffer.sv
// Two-bank TIA scanline store: one write port, one synchronous read port,
// each with its own bank select. Out-of-range reads return index 0 colour.
module tia_line_buffer #(
    parameter int DEPTH = 160,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_data
);
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    logic [6:0] bank0_r [DEPTH];
    logic [6:0] bank1_r [DEPTH];

    // Write port: one pixel into the selected bank
    always_ff @(posedge clk) begin
        if (we && (wr_addr < LIMIT)) begin
            if (wr_bank) begin
                bank1_r[wr_addr] <= wr_data;
            end else begin
                bank0_r[wr_addr] <= wr_data;
            end
        end
    end

    // Read port: registered, so data lines up one cycle after the address
    always_ff @(posedge clk) begin
        if (rd_addr >= LIMIT) begin
            rd_data <= 7'd0;
        end else if (rd_bank) begin
            rd_data <= bank1_r[rd_addr];
        end else begin
            rd_data <= bank0_r[rd_addr];
        end
    end
endmodule

// File: rtl/tia_vga_scaler.sv
// TIA scanline to 640x480@60 VGA scaler: ping-pong capture, 4x/2x replication,
// RGB222 palette. Define SCANLINES_EN to darken the odd line of each pair.
module tia_vga_scaler #(
    parameter int H_VISIBLE = 640,
    parameter int TIA_WIDTH = 160
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_valid,
    input  logic [6:0] pixel_color,
    input  logic       line_start,
    input  logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       underrun
);
    import tia_vga_pkg::*;

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [7:0] TIA_W    = 8'(TIA_WIDTH);

    logic [9:0] hcnt_r, vcnt_r;
    logic [7:0] widx_r, wr_idx_s;
    logic       ready_r, wbank_r, rbank_r, captured_r;
    logic       restart_s, we_s, swap_pt_s, do_swap_s, rd_bank_s, shown_s;
    logic       hs1_r, vs1_r, de1_r, blank1_r, ur1_r;
    logic [6:0] rd_data_s;
    rgb222_t    pal_s, lit_s, rgb_s;

    // Free-running VGA raster counters (stage 0)
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_r <= 10'd0;
            vcnt_r <= 10'd0;
        end else if (hcnt_r == H_LAST) begin
            hcnt_r <= 10'd0;
            vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : vcnt_r + 10'd1;
        end else begin
            hcnt_r <= hcnt_r + 10'd1;
        end
    end

    // Capture and swap control; the swap bank is bypassed so hcnt=0 already reads the new line
    always_comb begin
        restart_s = line_start && (widx_r != 8'd0);
        if (restart_s || frame_start) begin
            wr_idx_s = 8'd0;
        end else begin
            wr_idx_s = widx_r;
        end
        we_s      = pixel_valid && (wr_idx_s < TIA_W);
        swap_pt_s = (hcnt_r == 10'd0) && !vcnt_r[0] && (vcnt_r < V_VIS);
        do_swap_s = swap_pt_s && ready_r;
        if (do_swap_s) begin
            rd_bank_s = wbank_r;
        end else begin
            rd_bank_s = rbank_r;
        end
        shown_s = captured_r || do_swap_s;
    end

    // Write index, line-ready flag and bank ownership
    always_ff @(posedge clk) begin
        if (reset) begin
            widx_r     <= 8'd0;
            ready_r    <= 1'b0;
            wbank_r    <= 1'b0;
            rbank_r    <= 1'b1;
            captured_r <= 1'b0;
        end else begin
            widx_r <= we_s ? wr_idx_s + 8'd1 : wr_idx_s;
            if (frame_start) begin
                ready_r <= 1'b0;
            end else if (restart_s) begin
                ready_r <= 1'b1;
            end else if (do_swap_s) begin
                ready_r <= 1'b0;
            end
            if (do_swap_s) begin
                rbank_r <= wbank_r;
                wbank_r <= ~wbank_r;
            end
            captured_r <= shown_s;
        end
    end

    tia_line_buffer #(.DEPTH(TIA_WIDTH), .AW(8)) u_buf (
        .clk     (clk),
        .we      (we_s),
        .wr_bank (wbank_r),
        .wr_addr (wr_idx_s),
        .wr_data (pixel_color),
        .rd_bank (rd_bank_s),
        .rd_addr (hcnt_r[9:2]),
        .rd_data (rd_data_s)
    );

    // Stage 1: sync/enable decode, aligned with the buffer read
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1_r    <= 1'b1;
            vs1_r    <= 1'b1;
            de1_r    <= 1'b0;
            blank1_r <= 1'b1;
            ur1_r    <= 1'b0;
        end else begin
            hs1_r    <= !((hcnt_r >= HS_START) && (hcnt_r <= HS_END));
            vs1_r    <= !((vcnt_r >= VS_START) && (vcnt_r <= VS_END));
            de1_r    <= (hcnt_r < H_VIS) && (vcnt_r < V_VIS);
            blank1_r <= !shown_s;
            ur1_r    <= swap_pt_s && !ready_r;
        end
    end

`ifdef SCANLINES_EN
    logic odd1_r;

    // Stage 1: remember which line of the pair is being drawn
    always_ff @(posedge clk) begin
        if (reset) begin
            odd1_r <= 1'b0;
        end else begin
            odd1_r <= vcnt_r[0];
        end
    end
`endif

    // Stage 2 colour: palette, optional scanline darkening, blanking
    always_comb begin
        pal_s = tia_palette(rd_data_s);
`ifdef SCANLINES_EN
        if (odd1_r) begin
            lit_s = rgb_dim(pal_s);
        end else begin
            lit_s = pal_s;
        end
`else
        lit_s = pal_s;
`endif
        if (de1_r && !blank1_r) begin
            rgb_s = lit_s;
        end else begin
            rgb_s = '0;
        end
    end

    // Stage 2: output register
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            de       <= 1'b0;
            r        <= 2'd0;
            g        <= 2'd0;
            b        <= 2'd0;
            underrun <= 1'b0;
        end else begin
            hsync    <= hs1_r;
            vsync    <= vs1_r;
            de       <= de1_r;
            r        <= rgb_s.r;
            g        <= rgb_s.g;
            b        <= rgb_s.b;
            underrun <= ur1_r;
        end
    end
endmodule

// File: tb/tb_tia_vga_scaler.sv
// Self-checking bench for tia_vga_scaler: per-cycle raster model plus a table
// of hand-computed spot vectors, then a mid-frame reset and restart.
module tb_tia_vga_scaler;
    logic       clk = 1'b0;
    logic       reset, pixel_valid, line_start, frame_start;
    logic [6:0] pixel_color;
    logic       hsync, vsync, de, underrun;
    logic [1:0] r, g, b;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SCANLINES_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif
    localparam int RESET_K = 11500;

    // Per line pair: 0 black, 1 grey 3, 2 ramp, 3 grey 1; and whether the pair repeats
    int pat_tab [8] = '{0, 1, 2, 2, 2, 3, 3, 3};
    bit ur_tab  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    typedef struct {
        string name;
        int    k;
        bit    hs;
        bit    de;
        bit    ur;
        int    grey;
    } vec_t;
    vec_t tab[$];

    tia_vga_scaler dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .pixel_color (pixel_color),
        .line_start  (line_start),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .r           (r),
        .g           (g),
        .b           (b),
        .underrun    (underrun)
    );

    always #20 clk = ~clk;

    function automatic logic [9:0] pack(bit hs, bit vs, bit de_e, int grey, bit ur, bit odd);
        logic [1:0] gv;
        gv = 2'(grey);
        if (SCAN && odd) gv = gv >> 1;
        if (!de_e) gv = 2'b00;
        return {hs, vs, de_e, gv, gv, gv, ur};
    endfunction

    function automatic bit odd_of(int k);
        return (k >= 2) && ((((k - 2) / 800) % 2) == 1);
    endfunction

    function automatic logic [9:0] model(int k, bit after_reset);
        int c, hc, vc, p, grey;
        bit de_e, hs_e, vs_e, ur_e, odd;
        if (k < 2) return pack(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        c    = k - 2;
        hc   = c % 800;
        vc   = (c / 800) % 525;
        p    = (vc / 2) % 8;
        de_e = (hc < 640) && (vc < 480);
        hs_e = !((hc >= 656) && (hc <= 751));
        vs_e = !((vc >= 490) && (vc <= 491));
        odd  = (vc % 2) == 1;
        ur_e = (hc == 0) && !odd && (vc < 480) && (after_reset || ur_tab[p]);
        grey = 0;
        if (!after_reset) begin
            case (pat_tab[p])
                1:       grey = 3;
                2:       grey = ((hc / 4) % 8) / 2;
                3:       grey = 1;
                default: grey = 0;
            endcase
        end
        return pack(hs_e, vs_e, de_e, grey, ur_e, odd);
    endfunction

    task automatic check(string name, logic [9:0] exp);
        logic [9:0] got;
        got = {hsync, vsync, de, r, g, b, underrun};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {hs,vs,de,r,g,b,ur}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic add(string name, int k, bit hs, bit de_e, bit ur, int grey);
        vec_t v;
        v.name = name; v.k = k; v.hs = hs; v.de = de_e; v.ur = ur; v.grey = grey;
        tab.push_back(v);
    endtask

    task automatic drive(int k);
        pixel_valid = 1'b0;
        pixel_color = 7'h00;
        line_start  = 1'b0;
        frame_start = 1'b0;
        if (k >= 100 && k < 260) begin pixel_valid = 1'b1; pixel_color = 7'h07; end
        if (k >= 1700 && k < 1860) begin pixel_valid = 1'b1; pixel_color = 7'((k - 1700) % 8); end
        if (k >= 6500 && k < 6660) begin pixel_valid = 1'b1; pixel_color = 7'h05; end
        if (k >= 6660 && k < 6820) begin pixel_valid = 1'b1; pixel_color = 7'h03; end
        if (k >= 8100 && k < 8260) begin pixel_valid = 1'b1; pixel_color = 7'h07; end
        if (k == 400 || k == 2000 || k == 6660 || k == 6900 || k == 8300) line_start = 1'b1;
        if (k == 8500) frame_start = 1'b1;
    endtask

    initial begin
        add("rst_out",      0,    1'b1, 1'b0, 1'b0, 0);
        add("boot_ur",      2,    1'b1, 1'b1, 1'b1, 0);
        add("boot_black",   902,  1'b1, 1'b1, 1'b0, 0);
        add("hs_before",    657,  1'b1, 1'b0, 1'b0, 0);
        add("hs_fall",      658,  1'b0, 1'b0, 1'b0, 0);
        add("hs_last",      753,  1'b0, 1'b0, 1'b0, 0);
        add("hs_rise",      754,  1'b1, 1'b0, 1'b0, 0);
        add("grey_first",   1602, 1'b1, 1'b1, 1'b0, 3);
        add("grey_last",    2241, 1'b1, 1'b1, 1'b0, 3);
        add("blank_after",  2242, 1'b1, 1'b0, 1'b0, 0);
        add("grey_odd",     2419, 1'b1, 1'b1, 1'b0, 3);
        add("rep_pre",      3201, 1'b1, 1'b0, 1'b0, 0);
        add("rep_x0",       3202, 1'b1, 1'b1, 1'b0, 0);
        add("rep_x8",       3210, 1'b1, 1'b1, 1'b0, 1);
        add("rep_x20",      3222, 1'b1, 1'b1, 1'b0, 2);
        add("rep_x28",      3230, 1'b1, 1'b1, 1'b0, 3);
        add("rep_x31",      3233, 1'b1, 1'b1, 1'b0, 3);
        add("rep_x32",      3234, 1'b1, 1'b1, 1'b0, 0);
        add("ur_repeat",    4802, 1'b1, 1'b1, 1'b1, 0);
        add("ur_repeat2",   6402, 1'b1, 1'b1, 1'b1, 0);
        add("overrun_2nd",  8002, 1'b1, 1'b1, 1'b0, 1);
        add("same_cyc_idx0",8003, 1'b1, 1'b1, 1'b0, 1);
        add("fs_ur",        9602, 1'b1, 1'b1, 1'b1, 1);
        add("fs_repeat",    9922, 1'b1, 1'b1, 1'b0, 1);

        reset = 1'b1;
        drive(-1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k <= RESET_K; k++) begin
            drive(k);
            if (k == RESET_K) reset = 1'b1;
            @(negedge clk);
            check($sformatf("raster_k%0d", k), model(k, 1'b0));
            for (int i = 0; i < tab.size(); i++) begin
                if (tab[i].k == k)
                    check(tab[i].name, pack(tab[i].hs, 1'b1, tab[i].de, tab[i].grey, tab[i].ur, odd_of(k)));
            end
            @(posedge clk);
            #1;
        end

        for (int j = 0; j < 3; j++) begin
            drive(-1);
            @(negedge clk);
            check($sformatf("mid_reset_%0d", j), pack(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        for (int k = 0; k < 2400; k++) begin
            drive(-1);
            @(negedge clk);
            check($sformatf("restart_k%0d", k), model(k, 1'b1));
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
